// File: rtl/serialize_ctrl_pkg.sv
// Shared pipe definitions for the serialization controller: FSM states,
// serial-op kinds and kind decode.
package serialize_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    WAIT_RET = 2'd2,
    REFETCH  = 2'd3
  } ser_state_t;

  typedef logic [1:0] ser_kind_t;

  localparam ser_kind_t SER_NONE   = 2'd0;
  localparam ser_kind_t SER_CSR    = 2'd1;
  localparam ser_kind_t SER_FENCE  = 2'd2;
  localparam ser_kind_t SER_FENCEI = 2'd3;

  // FENCE.I outranks FENCE, which outranks CSR, when decode flags overlap.
  function automatic ser_kind_t ser_kind_of(logic is_csr, logic is_fence, logic is_fence_i);
    if (is_fence_i)    return SER_FENCEI;
    else if (is_fence) return SER_FENCE;
    else if (is_csr)   return SER_CSR;
    else               return SER_NONE;
  endfunction

endpackage

// File: rtl/serialize_ctrl_if.sv
// Pipe-side signal bundle of the serialization controller.
// slave = the controller, master = the pipeline driving it.
interface serialize_ctrl_if;
  import serialize_ctrl_pkg::*;

  logic      de_valid;
  logic      de_is_csr_op;
  logic      de_is_fence;
  logic      de_is_fence_i;
  logic      ex_is_a_inst;
  logic      m1_is_a_inst;
  logic      m2_is_a_inst;
  logic      wb_is_a_inst;
  logic      wb_is_serial;
  logic      hz_stall;
  logic      redirect;

  logic      stall_pc;
  logic      stall_f2;
  logic      stall_de;
  logic      flush_ex;
  logic      ser_issue;
  logic      flush_front;
  logic      ser_busy;
  ser_kind_t ser_kind;
  logic      ser_timeout;

  modport slave (
    input  de_valid, de_is_csr_op, de_is_fence, de_is_fence_i,
           ex_is_a_inst, m1_is_a_inst, m2_is_a_inst, wb_is_a_inst,
           wb_is_serial, hz_stall, redirect,
    output stall_pc, stall_f2, stall_de, flush_ex, ser_issue,
           flush_front, ser_busy, ser_kind, ser_timeout
  );

  modport master (
    output de_valid, de_is_csr_op, de_is_fence, de_is_fence_i,
           ex_is_a_inst, m1_is_a_inst, m2_is_a_inst, wb_is_a_inst,
           wb_is_serial, hz_stall, redirect,
    input  stall_pc, stall_f2, stall_de, flush_ex, ser_issue,
           flush_front, ser_busy, ser_kind, ser_timeout
  );

endinterface

// File: rtl/serialize_ctrl_ser_watchdog.sv
// Saturating watchdog counter: clear wins over enable, tc_o flags MAX_WAIT-1.
module serialize_ctrl_ser_watchdog #(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = $clog2(MAX_WAIT)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [CNT_W-1:0] TC = CNT_W'(MAX_WAIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && (cnt_q != TC))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == TC);

endmodule

// File: rtl/serialize_ctrl.sv
// Serialization controller: drains the back end around CSR/FENCE/FENCE.I,
// issues the serial op alone and holds younger work until it retires.
//
// state    | meaning
// IDLE     | no serial op in flight; watching DE
// DRAIN    | serial op held in DE, bubbles fed to EX until back end empty
// WAIT_RET | serial op issued, only bubbles follow until it retires in WB
// REFETCH  | one-cycle front-end refetch after FENCE.I retire
module serialize_ctrl
  import serialize_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = $clog2(MAX_WAIT)
) (
  input logic            clk,
  input logic            rst,
  serialize_ctrl_if.slave pipe
);

  ser_state_t state_q, state_d;
  ser_kind_t  kind_q, kind_d;
  logic       tmo_q, tmo_d;

  logic stall, flush_ex, issue, flush_front;
  logic wd_clr, wd_en, wd_tc;
  logic ser_req, be_empty, retire;

  assign ser_req  = pipe.de_valid & (pipe.de_is_csr_op | pipe.de_is_fence | pipe.de_is_fence_i);
  assign be_empty = ~(pipe.ex_is_a_inst | pipe.m1_is_a_inst | pipe.m2_is_a_inst | pipe.wb_is_a_inst);
  assign retire   = pipe.wb_is_a_inst & pipe.wb_is_serial;

  serialize_ctrl_ser_watchdog #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_watchdog (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (wd_clr),
    .en_i  (wd_en),
    .tc_o  (wd_tc)
  );

  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    tmo_d       = tmo_q;
    stall       = 1'b0;
    flush_ex    = 1'b0;
    issue       = 1'b0;
    flush_front = 1'b0;
    wd_clr      = 1'b0;
    wd_en       = 1'b0;

    unique case (state_q)
      IDLE: begin
        wd_clr = 1'b1;
        if (ser_req && !pipe.hz_stall && !pipe.redirect) begin
          kind_d = ser_kind_of(pipe.de_is_csr_op, pipe.de_is_fence, pipe.de_is_fence_i);
          if (be_empty) begin
            issue   = 1'b1;
            state_d = WAIT_RET;
          end else begin
            stall    = 1'b1;
            flush_ex = 1'b1;
            state_d  = DRAIN;
          end
        end
      end

      DRAIN: begin
        stall    = 1'b1;
        flush_ex = 1'b1;
        wd_en    = 1'b1;
        // Watchdog abort outranks issue so a dead controller never issues.
        if (wd_tc) begin
          tmo_d   = 1'b1;
          kind_d  = SER_NONE;
          state_d = IDLE;
        end else if (pipe.redirect) begin
          kind_d  = SER_NONE;
          state_d = IDLE;
        end else if (be_empty && !pipe.hz_stall) begin
          issue    = 1'b1;
          stall    = 1'b0;
          flush_ex = 1'b0;
          wd_clr   = 1'b1;
          state_d  = WAIT_RET;
        end
      end

      WAIT_RET: begin
        stall    = 1'b1;
        flush_ex = 1'b1;
        wd_en    = 1'b1;
        if (wd_tc) begin
          tmo_d   = 1'b1;
          kind_d  = SER_NONE;
          state_d = IDLE;
        end else if (pipe.redirect) begin
          kind_d  = SER_NONE;
          state_d = IDLE;
        end else if (retire) begin
          if (kind_q == SER_FENCEI) begin
            state_d = REFETCH;
          end else begin
            kind_d  = SER_NONE;
            state_d = IDLE;
          end
        end
      end

      REFETCH: begin
        flush_front = ~pipe.redirect;
        kind_d      = SER_NONE;
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      kind_q  <= SER_NONE;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      tmo_q   <= tmo_d;
    end
  end

  // Combinational outputs are forced quiet while reset is held.
  assign pipe.stall_pc    = stall & ~rst;
  assign pipe.stall_f2    = stall & ~rst;
  assign pipe.stall_de    = stall & ~rst;
  assign pipe.flush_ex    = flush_ex & ~rst;
  assign pipe.ser_issue   = issue & ~rst;
  assign pipe.flush_front = flush_front & ~rst;
  assign pipe.ser_busy    = (state_q != IDLE) & ~rst;
  assign pipe.ser_kind    = kind_q;
  assign pipe.ser_timeout = tmo_q;

endmodule

// File: tb/tb_serialize_ctrl.sv
// Self-checking bench for serialize_ctrl: directed vector table, watchdog and
// reset sequences, then randomized traffic against a flag-based reference model.
module tb_serialize_ctrl;

  localparam int MAXW = 8;

  typedef struct packed {
    logic rst;
    logic dv, csr, fence, fencei;
    logic ex, m1, m2, wb;
    logic wbs, hz, rd;
  } in_t;

  // expected: {stall, flush_ex, issue, flush_front, busy, kind[1:0], timeout}
  typedef struct {
    string      nm;
    in_t        i;
    logic [7:0] e;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serialize_ctrl_if pipe ();

  serialize_ctrl #(.MAX_WAIT(MAXW)) dut (
    .clk  (clk),
    .rst  (rst),
    .pipe (pipe)
  );

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];

  // reference model state
  logic       m_active, m_issued, m_refetch, m_tmo;
  logic [1:0] m_kind;
  int         m_age;

  function automatic void add(string nm, in_t i, logic [7:0] e);
    vec_t v;
    v.nm = nm; v.i = i; v.e = e;
    tbl.push_back(v);
  endfunction

  task automatic drive(input in_t x);
    rst                = x.rst;
    pipe.de_valid      = x.dv;
    pipe.de_is_csr_op  = x.csr;
    pipe.de_is_fence   = x.fence;
    pipe.de_is_fence_i = x.fencei;
    pipe.ex_is_a_inst  = x.ex;
    pipe.m1_is_a_inst  = x.m1;
    pipe.m2_is_a_inst  = x.m2;
    pipe.wb_is_a_inst  = x.wb;
    pipe.wb_is_serial  = x.wbs;
    pipe.hz_stall      = x.hz;
    pipe.redirect      = x.rd;
  endtask

  task automatic apply(input in_t x, input logic [7:0] e, input string nm);
    logic [9:0] act, exp10;
    @(negedge clk);
    drive(x);
    #2;
    act   = {pipe.stall_pc, pipe.stall_f2, pipe.stall_de, pipe.flush_ex, pipe.ser_issue,
             pipe.flush_front, pipe.ser_busy, pipe.ser_kind, pipe.ser_timeout};
    exp10 = {e[7], e[7], e[7:0]};
    checks++;
    if (act !== exp10) begin
      errors++;
      $display("FAIL %s @%0t: got %b expected %b (pc f2 de fex iss ff busy kind tmo)",
               nm, $time, act, exp10);
    end
  endtask

  task automatic model_step(input in_t x, output logic [7:0] e);
    logic st, fx, is, ff, empty, req;
    logic [1:0] k;
    st = 1'b0; fx = 1'b0; is = 1'b0; ff = 1'b0;
    empty = !(x.ex | x.m1 | x.m2 | x.wb);
    req   = x.dv & (x.csr | x.fence | x.fencei);
    k     = x.fencei ? 2'd3 : (x.fence ? 2'd2 : 2'd1);
    e     = {4'b0000, (!x.rst && (m_active || m_refetch)), m_kind, m_tmo};
    if (x.rst) begin
      m_active = 0; m_issued = 0; m_refetch = 0; m_tmo = 0; m_kind = 0; m_age = 0;
    end else if (m_refetch) begin
      ff = !x.rd; m_refetch = 0; m_kind = 0;
    end else if (!m_active) begin
      if (req && !x.hz && !x.rd) begin
        m_kind = k; m_active = 1; m_age = 0;
        if (empty) begin is = 1; m_issued = 1; end
        else begin st = 1; fx = 1; m_issued = 0; end
      end
    end else begin
      st = 1; fx = 1;
      if (m_age == MAXW - 1) begin
        m_tmo = 1; m_active = 0; m_kind = 0;
      end else if (x.rd) begin
        m_active = 0; m_kind = 0;
      end else if (!m_issued) begin
        if (empty && !x.hz) begin
          is = 1; st = 0; fx = 0; m_issued = 1; m_age = 0;
        end else m_age++;
      end else if (x.wb && x.wbs) begin
        m_active = 0;
        if (m_kind == 2'd3) m_refetch = 1;
        else m_kind = 0;
      end else m_age++;
    end
    e[7:4] = {st, fx, is, ff};
  endtask

  initial begin
    in_t x;
    logic [7:0] e;

    drive(12'b1_0000_0000_000);
    @(negedge clk);
    @(negedge clk);

    // in: rst | dv csr fence fencei | ex m1 m2 wb | wbs hz rd
    add("reset",         12'b1_0000_0000_000, 8'b0000_0_00_0);
    add("idle_noreq",    12'b0_0000_0000_000, 8'b0000_0_00_0);
    add("idle_dv0",      12'b0_0100_0000_000, 8'b0000_0_00_0);
    // CSR with empty back end
    add("csr_issue",     12'b0_1100_0000_000, 8'b0010_0_00_0);
    add("csr_wait_ex",   12'b0_1000_1000_000, 8'b1100_1_01_0);
    add("csr_wait_m1",   12'b0_1000_0100_000, 8'b1100_1_01_0);
    add("csr_wait_m2",   12'b0_1000_0010_000, 8'b1100_1_01_0);
    add("csr_retire",    12'b0_1000_0001_100, 8'b1100_1_01_0);
    add("csr_idle",      12'b0_1000_0000_000, 8'b0000_0_00_0);
    // FENCE with full back end draining one per cycle
    add("fence_accept",  12'b0_1010_1111_000, 8'b1100_0_00_0);
    add("fence_drain1",  12'b0_1010_0111_000, 8'b1100_1_10_0);
    add("fence_drain2",  12'b0_1010_0011_000, 8'b1100_1_10_0);
    add("fence_drain3",  12'b0_1010_0001_000, 8'b1100_1_10_0);
    add("fence_issue",   12'b0_1010_0000_000, 8'b0010_1_10_0);
    add("fence_wait_ex", 12'b0_1000_1000_000, 8'b1100_1_10_0);
    add("fence_wait_m1", 12'b0_1000_0100_000, 8'b1100_1_10_0);
    add("fence_wait_m2", 12'b0_1000_0010_000, 8'b1100_1_10_0);
    add("fence_retire",  12'b0_1000_0001_100, 8'b1100_1_10_0);
    add("fence_idle",    12'b0_0000_0000_000, 8'b0000_0_00_0);
    // FENCE.I then back-to-back CSR
    add("fi_issue",      12'b0_1001_0000_000, 8'b0010_0_00_0);
    add("fi_wait_ex",    12'b0_1000_1000_000, 8'b1100_1_11_0);
    add("fi_wait_m1",    12'b0_1000_0100_000, 8'b1100_1_11_0);
    add("fi_wait_m2",    12'b0_1000_0010_000, 8'b1100_1_11_0);
    add("fi_retire",     12'b0_1000_0001_100, 8'b1100_1_11_0);
    add("fi_refetch",    12'b0_1100_0000_000, 8'b0001_1_11_0);
    add("b2b_csr_issue", 12'b0_1100_0000_000, 8'b0010_0_00_0);
    add("b2b_redirect",  12'b0_1000_1000_001, 8'b1100_1_01_0);
    add("b2b_idle",      12'b0_0000_0000_000, 8'b0000_0_00_0);
    // redirect in DRAIN
    add("rd_accept",     12'b0_1010_1111_000, 8'b1100_0_00_0);
    add("rd_drain1",     12'b0_1010_0111_000, 8'b1100_1_10_0);
    add("rd_drain2_rd",  12'b0_1010_0011_001, 8'b1100_1_10_0);
    add("rd_idle",       12'b0_0000_0001_000, 8'b0000_0_00_0);
    // redirect together with FENCE.I retire
    add("rr_issue",      12'b0_1001_0000_000, 8'b0010_0_00_0);
    add("rr_wait_ex",    12'b0_0000_1000_000, 8'b1100_1_11_0);
    add("rr_wait_m1",    12'b0_0000_0100_000, 8'b1100_1_11_0);
    add("rr_wait_m2",    12'b0_0000_0010_000, 8'b1100_1_11_0);
    add("rr_retire_rd",  12'b0_0000_0001_101, 8'b1100_1_11_0);
    add("rr_no_ff",      12'b0_0000_0000_000, 8'b0000_0_00_0);
    // hz_stall in IDLE and in DRAIN
    add("hz_idle1",      12'b0_1100_0000_010, 8'b0000_0_00_0);
    add("hz_idle2",      12'b0_1100_0000_010, 8'b0000_0_00_0);
    add("hz_accept",     12'b0_1100_0001_000, 8'b1100_0_00_0);
    add("hz_drain1",     12'b0_1100_0000_010, 8'b1100_1_01_0);
    add("hz_drain2",     12'b0_1100_0000_010, 8'b1100_1_01_0);
    add("hz_release",    12'b0_1100_0000_000, 8'b0010_1_01_0);
    add("hz_wait_rd",    12'b0_0000_1000_001, 8'b1100_1_01_0);
    add("hz_idle",       12'b0_0000_0000_000, 8'b0000_0_00_0);
    // redirect during REFETCH suppresses flush_front
    add("rf_issue",      12'b0_1001_0000_000, 8'b0010_0_00_0);
    add("rf_retire",     12'b0_0000_0001_100, 8'b1100_1_11_0);
    add("rf_refetch_rd", 12'b0_0000_0000_001, 8'b0000_1_11_0);
    add("rf_idle",       12'b0_0000_0000_000, 8'b0000_0_00_0);
    // kind priority
    add("prio_all",      12'b0_1111_0000_000, 8'b0010_0_00_0);
    add("prio_all_rd",   12'b0_0000_0000_001, 8'b1100_1_11_0);
    add("prio_cf",       12'b0_1110_0000_000, 8'b0010_0_00_0);
    add("prio_cf_rd",    12'b0_0000_0000_001, 8'b1100_1_10_0);
    add("prio_idle",     12'b0_0000_0000_000, 8'b0000_0_00_0);

    for (int n = 0; n < tbl.size(); n++)
      apply(tbl[n].i, tbl[n].e, tbl[n].nm);

    // watchdog: CSR issued, never retires
    apply(12'b0_1100_0000_000, 8'b0010_0_00_0, "wd_issue");
    for (int k = 0; k < MAXW; k++)
      apply(12'b0_0000_0000_000, 8'b1100_1_01_0, "wd_wait");
    apply(12'b0_0000_0000_000, 8'b0000_0_00_1, "wd_abort_idle");
    apply(12'b0_0000_0000_000, 8'b0000_0_00_1, "wd_sticky");
    apply(12'b0_1100_0000_000, 8'b0010_0_00_1, "wd_sticky_issue");
    // reset while in WAIT_RET
    apply(12'b1_0000_1000_000, 8'b0000_0_01_1, "rst_in_wait");
    apply(12'b0_0000_0000_000, 8'b0000_0_00_0, "after_rst");

    // randomized traffic against the reference model
    m_active = 0; m_issued = 0; m_refetch = 0; m_tmo = 0; m_kind = 0; m_age = 0;
    for (int c = 0; c < 4000; c++) begin
      x.rst    = ($urandom_range(0, 249) == 0);
      x.dv     = ($urandom_range(0, 3) != 0);
      x.csr    = ($urandom_range(0, 2) == 0);
      x.fence  = ($urandom_range(0, 2) == 0);
      x.fencei = ($urandom_range(0, 2) == 0);
      x.ex     = $urandom_range(0, 1) == 1;
      x.m1     = $urandom_range(0, 1) == 1;
      x.m2     = $urandom_range(0, 1) == 1;
      x.wb     = $urandom_range(0, 1) == 1;
      x.wbs    = ($urandom_range(0, 2) == 0);
      x.hz     = ($urandom_range(0, 4) == 0);
      x.rd     = ($urandom_range(0, 11) == 0);
      model_step(x, e);
      apply(x, e, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serialize_ctrl.md
Name: serialize_ctrl

Overview:
- Serialization controller for the F1/F2/DE/EX/M1/M2/WB pipe.
- When DE holds a CSR op, FENCE or FENCE.I, the block does the following:
  - drains every older instruction from EX..WB;
  - lets the serial op issue alone;
  - holds younger instructions until the serial op retires;
  - for FENCE.I, requests a front-end refetch.
- Outputs are ORed at top level with the load-use hazard unit's stall/flush outputs.
- The load-use hazard unit keeps priority.

Parameters:
- MAX_WAIT, 64, cycles allowed in DRAIN+WAIT_RET before watchdog abort.
- CNT_W, $clog2(MAX_WAIT), watchdog counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- de_valid  in  1  DE holds a valid instruction
- de_is_csr_op  in  1  DE instruction is a CSR op
- de_is_fence  in  1  DE instruction is FENCE
- de_is_fence_i  in  1  DE instruction is FENCE.I
- ex_is_a_inst  in  1  EX occupied
- m1_is_a_inst  in  1  M1 occupied
- m2_is_a_inst  in  1  M2 occupied
- wb_is_a_inst  in  1  WB occupied
- wb_is_serial  in  1  WB instruction is the tagged serial op
- hz_stall  in  1  load-use stall active this cycle
- redirect  in  1  branch/trap flush of DE and younger
- stall_pc  out  1  hold PC
- stall_f2  out  1  hold F2
- stall_de  out  1  hold DE
- flush_ex  out  1  insert bubble into EX
- ser_issue  out  1  serial op moves DE->EX this cycle; EX tags it serial
- flush_front  out  1  one-cycle refetch request after FENCE.I
- ser_busy  out  1  state != IDLE
- ser_kind  out  2  latched kind: 0 none, 1 CSR, 2 FENCE, 3 FENCE.I
- ser_timeout  out  1  sticky watchdog error

Behaviour:
- Definitions:
  - ser_req = de_valid & (de_is_csr_op | de_is_fence | de_is_fence_i)
  - be_empty = !(ex|m1|m2|wb _is_a_inst)
  - Kind priority when several flags are set: FENCE.I > FENCE > CSR.
- Reset (sync, rst=1):
  - state IDLE, counter 0, ser_kind 0, ser_timeout 0.
  - All combinational outputs 0 during the reset cycle.
- States: IDLE, DRAIN, WAIT_RET, REFETCH. Stall/flush outputs are combinational from state plus inputs.
- IDLE:
  - If redirect, or hz_stall, or !ser_req: all outputs 0, stay.
  - Else latch ser_kind and clear the counter, then:
    - if be_empty: ser_issue=1, stalls 0, go WAIT_RET (zero-penalty issue);
    - otherwise: stall_pc/f2/de=1, flush_ex=1, go DRAIN.
- DRAIN:
  - stall_pc/f2/de=1 and flush_ex=1; counter increments each cycle.
  - redirect → IDLE; serial op is killed, ser_kind←0.
  - Else if be_empty & !hz_stall: ser_issue=1, stall_pc/f2/de=0, flush_ex=0, counter←0, go WAIT_RET.
- WAIT_RET:
  - stall_pc/f2/de=1 and flush_ex=1 every cycle, so only bubbles follow the serial op.
  - Counter increments each cycle.
  - redirect → IDLE; the serial op trapped and will not retire.
  - wb_is_a_inst & wb_is_serial:
    - kind==3 → REFETCH;
    - otherwise → IDLE with ser_kind←0.
  - Retire and redirect in the same cycle: redirect wins; no REFETCH.
- REFETCH:
  - Exactly one cycle: flush_front=1, stalls 0, ser_kind←0, next IDLE.
  - If redirect is asserted, flush_front=0; the redirect target wins.
- Watchdog:
  - If the counter equals MAX_WAIT-1 in DRAIN or WAIT_RET, then ser_timeout←1 (sticky until rst) and next state is IDLE.
  - No REFETCH on abort; that cycle's stall/flush outputs still follow the current state.
  - Counter saturates and never wraps.
- ser_issue is only ever a single-cycle pulse per serial op.
  - The DE instruction must not re-trigger after issue.
  - In WAIT_RET, DE holds the next younger instruction. When that instruction is itself serial, it is accepted only after returning to IDLE.
- Back-to-back serial ops: the second one is seen in IDLE on the cycle after retire (or after REFETCH). It normally issues immediately because the back end holds only bubbles.
- rst asserted in any state: next state IDLE; no flush_front pulse.

Decomposition:
- Shared pipe package:
  - ser_state_t enum: IDLE=0, DRAIN=1, WAIT_RET=2, REFETCH=3.
  - ser_kind_t constants: SER_NONE, SER_CSR, SER_FENCE, SER_FENCEI.
  - These live alongside the existing MEM_READ-style op defines.
- One natural sub-module, ser_watchdog: a saturating CNT_W counter with clear, enable, and a terminal-count flag.

Test Plan:
- Empty back end:
  - Stimulus: CSR in DE, all *_is_a_inst=0.
  - Response: ser_issue=1 same cycle, no stalls. Stalls/flush_ex=1 in each WAIT_RET cycle. Retire at WB 4 cycles later → IDLE, ser_kind back to 0.
- Drain:
  - Stimulus: FENCE in DE with EX, M1, M2 and WB all occupied; these drain one per cycle.
  - Response: DRAIN for 4 cycles with stall_pc=1 and flush_ex=1. ser_issue on the 5th cycle, then WAIT_RET.
- FENCE.I:
  - Stimulus: FENCE.I issues and later retires.
  - Response: exactly one flush_front=1 cycle on the cycle after the WB retire, then IDLE.
- Redirect:
  - Stimulus: redirect in DRAIN at cycle 2.
  - Response: next cycle is IDLE, ser_issue never pulses, ser_kind=0.
  - Stimulus: redirect in WAIT_RET on the same cycle as FENCE.I retire.
  - Response: flush_front stays 0.
- hz_stall:
  - Stimulus: hz_stall=1 in IDLE with a CSR in DE.
  - Response: no outputs, state stays IDLE.
  - Stimulus: hz_stall=1 in DRAIN with be_empty.
  - Response: no ser_issue until hz_stall drops.
- Watchdog:
  - Stimulus: MAX_WAIT=8, CSR issued, wb_is_serial held 0.
  - Response: ser_timeout=1 the cycle after the 8th WAIT_RET cycle, state IDLE, sticky until rst.
  - Stimulus: rst in WAIT_RET.
  - Response: all outputs 0, IDLE.
